ladybird_debounce: RTL and testbench
====================================

Name: ladybird_debounce

Overview:
- Input conditioning stage placed directly upstream of the GPIO peripheral. Raw board switches and buttons enter here.
- Each bit passes through a synchronizer, then a per-bit stability filter paced by a shared prescaler tick.
- Outputs: a clean debounced level vector that drives the GPIO block's GPIO_I, plus one-cycle rise/fall event pulses.

Parameters:
- WIDTH, 8, number of input bits (E_WIDTH*N_INPUT of the GPIO block).
- SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4.
- TICK_DIV, 100000, clock cycles per sample tick; legal range >=1 (1 = tick every cycle).
- STABLE_TICKS, 16, consecutive differing ticks required before a level change is accepted; legal range >=1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous and active-high.
- raw_i  input  WIDTH  asynchronous raw pad inputs, active-high.
- level_o  output  WIDTH  debounced level; connects to GPIO_I.
- rise_o  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- fall_o  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- tick_o  output  1  prescaler tick, exported for bench observation.

Behaviour:
- Reset (rst high at a clk edge):
  - Synchronizer flops, level_o, rise_o, fall_o, all per-bit counters and the prescaler are cleared to 0.
  - tick_o is 0 during reset; if TICK_DIV=1, tick_o is constant 1.
  - Reset asserted mid-count discards all progress, with no pulse emitted.
- Synchronizer:
  - SYNC_STAGES-deep flop chain per bit.
  - s = last stage. No logic is placed between stages.
- Prescaler:
  - Counter pc of width clog2(TICK_DIV), max 1; counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (pc == TICK_DIV-1), combinational from pc, high for exactly one cycle per period.
  - TICK_DIV=1: tick is constantly 1.
- Per-bit filter (2 states, derived from comparison):
  - Each bit has counter cnt of width clog2(STABLE_TICKS), min 1.
  - IDLE (s == level): cnt <= 0. No tick is required.
  - PENDING (s != level), on tick:
    - if cnt == STABLE_TICKS-1: level <= s, cnt <= 0, and pulse rise (s=1) or fall (s=0) for the next cycle only.
    - else cnt <= cnt+1.
  - PENDING without tick: hold cnt.
  - Any cycle with s == level (a glitch back) clears cnt immediately, even between ticks.
  - cnt never exceeds STABLE_TICKS-1. No wrap-around is possible.
- Pulses:
  - rise_o/fall_o are registered and asserted in the same cycle level_o first shows the new value.
  - rise_o and fall_o are never both set for one bit.
  - Multiple bits may pulse simultaneously.
- Latency (TICK_DIV=1):
  - level_o changes SYNC_STAGES+STABLE_TICKS clk edges after the first edge at which raw_i is sampled at the new value.
  - A raw excursion shorter than STABLE_TICKS cycles is fully rejected.
- Bits are independent. The only shared element is the prescaler.

Test Plan:
- Reset: rst=1 for 3 cycles with raw_i=8'hFF -> level_o=0, rise_o=0, fall_o=0, tick_o=0. After release, with TICK_DIV=1, STABLE_TICKS=4, SYNC_STAGES=2: level_o becomes 8'hFF exactly 6 edges after the first sampled edge, and rise_o=8'hFF for exactly that one cycle.
- Glitch filter (TICK_DIV=1, STABLE_TICKS=4):
  - raw_i[0] high for 3 cycles then low -> level_o[0] stays 0, no rise_o pulse.
  - Same test with 4 cycles -> level_o[0]=1 after 6 edges, rise_o[0] pulses once.
- Release: level_o[2]=1 established, then raw_i[2] low and held -> after 6 edges level_o[2]=0 and fall_o[2] pulses once; rise_o stays 0.
- Prescaler (TICK_DIV=5, STABLE_TICKS=3):
  - tick_o high every 5th cycle.
  - A held change is accepted on the 3rd tick after s differs from level.
  - A one-cycle bounce back between ticks clears cnt, and the count restarts from 0.
- Simultaneous bits: raw_i goes 8'h00->8'hA5 in one cycle -> level_o=8'hA5 and rise_o=8'hA5 in the same cycle. Then 8'hA5->8'h5A -> fall_o=8'hA5 and rise_o=8'h5A together.
- Reset mid-count: raw_i[1] held high, rst pulsed for 1 cycle when cnt=2 -> no pulse. Counting restarts, and level_o[1] rises a full 6 edges after rst deasserts.

Source files
------------

// File: rtl/ladybird_debounce.sv
// ladybird_debounce: synchronizes raw pad inputs and debounces each bit with
//   a counter paced by a shared prescaler tick, producing level/rise/fall outputs.
// Latency: level_o follows a held raw change after SYNC_STAGES + STABLE_TICKS ticks' worth of edges.
// Backpressure: none; this is a free-running conditioning stage with no handshake.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   raw_i    asynchronous raw pad inputs (active-high)
//   level_o  debounced level vector (feeds GPIO_I)
//   rise_o   one-cycle pulse per bit on an accepted 0->1 change
//   fall_o   one-cycle pulse per bit on an accepted 1->0 change
//   tick_o   prescaler sample tick
module ladybird_debounce #(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             tick_o
);

    localparam int PCW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int CW  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [PCW-1:0] PC_LAST  = PCW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    // ------------------------------------------------------------------
    // Synchronizer: plain flop chain, stage 0 samples the pad.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Prescaler: counts 0..TICK_DIV-1. With TICK_DIV=1 the counter sits at
    // 0, which equals PC_LAST, so the tick is permanently high.
    // ------------------------------------------------------------------
    logic [PCW-1:0] r_pc;
    logic           w_tick;

    assign w_tick = (r_pc == PC_LAST);
    assign tick_o = w_tick;

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + PCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-bit stability filter. A bit is "pending" whenever the synchronized
    // input disagrees with the accepted level; any agreeing cycle wipes the
    // progress immediately, tick or not.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          r_level;
    logic [WIDTH-1:0]          r_rise;
    logic [WIDTH-1:0]          r_fall;
    logic [WIDTH-1:0][CW-1:0]  r_cnt;

    logic [WIDTH-1:0]          w_level_nxt;
    logic [WIDTH-1:0]          w_rise_nxt;
    logic [WIDTH-1:0]          w_fall_nxt;
    logic [WIDTH-1:0][CW-1:0]  w_cnt_nxt;

    always_comb begin
        w_level_nxt = r_level;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        w_cnt_nxt   = r_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_s[i] == r_level[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (w_tick) begin
                if (r_cnt[i] == CNT_LAST) begin
                    // Accept: pulse is registered alongside the new level so
                    // both appear in the same cycle.
                    w_level_nxt[i] = w_s[i];
                    w_cnt_nxt[i]   = '0;
                    w_rise_nxt[i]  = w_s[i];
                    w_fall_nxt[i]  = ~w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_cnt   <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

endmodule

// File: tb/tb_ladybird_debounce.sv
// Directed bench for ladybird_debounce: one instance with TICK_DIV=1/STABLE_TICKS=4
// and one with TICK_DIV=5/STABLE_TICKS=3, both SYNC_STAGES=2, WIDTH=8.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_ladybird_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic [7:0] level, rise, fall;
    logic       tick;
    logic [7:0] raw5;
    logic [7:0] level5, rise5, fall5;
    logic       tick5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ladybird_debounce #(
        .WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4)
    ) dut (
        .clk(clk), .rst(rst), .raw_i(raw),
        .level_o(level), .rise_o(rise), .fall_o(fall), .tick_o(tick)
    );

    ladybird_debounce #(
        .WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(5), .STABLE_TICKS(3)
    ) dut5 (
        .clk(clk), .rst(rst), .raw_i(raw5),
        .level_o(level5), .rise_o(rise5), .fall_o(fall5), .tick_o(tick5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold raw at new_raw for 7 edges starting from a settled old level;
    // the change lands on edge 6 with a single pulse.
    task automatic run_change(input string tag, input logic [7:0] new_raw, input logic [7:0] old_lvl);
        raw = new_raw;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk({tag, "_level"}, {24'h0, level}, {24'h0, (k >= 6) ? new_raw : old_lvl});
            chk({tag, "_rise"},  {24'h0, rise},  {24'h0, (k == 6) ? (new_raw & ~old_lvl) : 8'h00});
            chk({tag, "_fall"},  {24'h0, fall},  {24'h0, (k == 6) ? (old_lvl & ~new_raw) : 8'h00});
        end
    endtask

    initial begin
        rst  = 1'b1;
        raw  = 8'hFF;
        raw5 = 8'h00;

        // Reset held for three edges with raw high.
        for (int k = 0; k < 3; k++) step();
        chk("rst_level", {24'h0, level}, 32'h0);
        chk("rst_rise",  {24'h0, rise},  32'h0);
        chk("rst_fall",  {24'h0, fall},  32'h0);
        chk("rst_tick1", {31'h0, tick},  32'h1);
        chk("rst_tick5", {31'h0, tick5}, 32'h0);
        chk("rst_level5", {24'h0, level5}, 32'h0);

        // Release: all bits accepted on edge 6.
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("por_level", {24'h0, level}, (k >= 6) ? 32'hFF : 32'h0);
            chk("por_rise",  {24'h0, rise},  (k == 6) ? 32'hFF : 32'h0);
            chk("por_fall",  {24'h0, fall},  32'h0);
        end

        // Keep only bit 2 high, then release bit 2.
        run_change("keep2", 8'h04, 8'hFF);
        run_change("rel2",  8'h00, 8'h04);

        // Glitch of 3 cycles on bit 0 is rejected.
        raw = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) raw = 8'h00;
            chk("g3_level", {24'h0, level}, 32'h0);
            chk("g3_rise",  {24'h0, rise},  32'h0);
        end

        // 4-cycle pulse on bit 0 is accepted at edge 6, then released at edge 10.
        raw = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) raw = 8'h00;
            chk("g4_level", {24'h0, level}, (k >= 6 && k < 10) ? 32'h1 : 32'h0);
            chk("g4_rise",  {24'h0, rise},  (k == 6)  ? 32'h1 : 32'h0);
            chk("g4_fall",  {24'h0, fall},  (k == 10) ? 32'h1 : 32'h0);
        end

        // Several bits changing together.
        run_change("simA5", 8'hA5, 8'h00);
        run_change("sim5A", 8'h5A, 8'hA5);
        run_change("clr",   8'h00, 8'h5A);

        // Reset mid-count on bit 1 (after the edge where cnt reaches 2).
        raw = 8'h02;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("mid_pre_level", {24'h0, level}, 32'h0);
        end
        rst = 1'b1;
        step();
        chk("mid_rst_level", {24'h0, level}, 32'h0);
        chk("mid_rst_rise",  {24'h0, rise},  32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("mid_level", {24'h0, level}, (k >= 6) ? 32'h02 : 32'h0);
            chk("mid_rise",  {24'h0, rise},  (k == 6) ? 32'h02 : 32'h0);
        end

        // Prescaler instance: fresh reset aligns the tick phase (pc=0 at t=0).
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("p_tick_t0", {31'h0, tick5}, 32'h0);
        for (int t = 1; t <= 47; t++) begin
            step();
            chk("p_tick", {31'h0, tick5}, ((t % 5) == 4) ? 32'h1 : 32'h0);
            // Held rise: s differs from t=12, ticks consumed at edges 15/20/25.
            // Fall from t=28 with a one-cycle bounce at t=32: count restarts,
            // so acceptance moves from edge 40 to edge 45.
            chk("p_level", {24'h0, level5}, (t >= 25 && t < 45) ? 32'h1 : 32'h0);
            chk("p_rise",  {24'h0, rise5},  (t == 25) ? 32'h1 : 32'h0);
            chk("p_fall",  {24'h0, fall5},  (t == 45) ? 32'h1 : 32'h0);
            if (t == 10) raw5 = 8'h01;
            if (t == 26) raw5 = 8'h00;
            if (t == 30) raw5 = 8'h01;
            if (t == 31) raw5 = 8'h00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
